adma_xfer_sched: RTL and testbench

ADMA_XFER_SCHED -- requirements
Module: adma_xfer_sched

---
 rtl/adma_xfer_sched_pkg.sv | 31 +++
 rtl/adma_xfer_sched_beat_counter.sv | 36 +++
 rtl/adma_xfer_sched.sv | 108 ++++++++++
 tb/tb_adma_xfer_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_xfer_sched_pkg.sv
// Shared definitions for the ADMA transfer scheduler: register bit positions,
// default beat width and the scheduler state encoding.
package adma_xfer_sched_pkg;

  localparam int WORD_BYTES_DEF = 4;

  // transfer_mode_register_in bits
  localparam int TM_DMA_EN  = 0;
  localparam int TM_CNT_EN  = 1;
  localparam int TM_DIR     = 4;
  localparam int TM_MULTI   = 5;

  // block_gap_control_register bits
  localparam int BG_STOP    = 0;
  localparam int BG_CONT    = 1;

  // command_register type field
  localparam int CMD_TYPE_HI = 7;
  localparam int CMD_TYPE_LO = 6;
  localparam logic [1:0] CMD_TYPE_DATA = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_XFER     = 3'd2,
    ST_GAP_CHK  = 3'd3,
    ST_GAP_STOP = 3'd4,
    ST_DONE     = 3'd5
  } xfer_state_e;

endpackage

// File: rtl/adma_xfer_sched_beat_counter.sv
// Per-block beat counter: latches ceil(block_size / WORD_BYTES) on load and
// flags the beat that completes the block.
module adma_beat_counter
  import adma_xfer_sched_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        beat_en,
  input  logic [11:0] block_size,
  output logic        last_beat,
  output logic [11:0] beat_cnt
);

  logic [11:0] wpb_q;

  assign last_beat = beat_en && ((beat_cnt + 12'd1) == wpb_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wpb_q    <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      wpb_q    <= 12'((32'(block_size) + WORD_BYTES - 1) / WORD_BYTES);
      beat_cnt <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (beat_en) begin
      beat_cnt <= last_beat ? 12'd0 : beat_cnt + 12'd1;
    end
  end

endmodule

// File: rtl/adma_xfer_sched.sv
// ADMA block transfer scheduler: starts on a data-command write, sequences
// blocks of beats, honours stop-at-block-gap / continue and DMA-enable abort.
module adma_xfer_sched
  import adma_xfer_sched_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       transfer_mode_register_in,
  input  logic [15:0]       block_gap_control_register,
  input  logic [15:0]       block_size_register,
  input  logic [15:0]       block_count_register,
  input  logic [15:0]       command_register,
  input  logic              beat_valid,
  output logic              beat_ready,
  output logic              blk_start,
  output logic              xfer_active,
  output logic              direction,
  output logic              gap_stopped,
  output logic              xfer_complete,
  output logic [CNT_W-1:0]  blocks_remaining,
  output xfer_state_e       state_dbg
);

  // Handshake: a beat is consumed on any rising CLK where beat_valid and
  // beat_ready are both high; beat_ready is high only in XFER, and
  // beat_valid while beat_ready is low is ignored.

  xfer_state_e state, state_next;
  logic        cmd_prev, start_q, dir_q, blk_start_q;
  logic [CNT_W-1:0] rem_q;
  logic        last_beat;
  logic [11:0] beat_cnt;

  logic cmd_is_data, dma_en, stop_gap, cont_req, arm_ok;
  logic [CNT_W-1:0] arm_blocks;

  assign cmd_is_data = (command_register[CMD_TYPE_HI:CMD_TYPE_LO] == CMD_TYPE_DATA);
  assign dma_en      = transfer_mode_register_in[TM_DMA_EN];
  assign stop_gap    = block_gap_control_register[BG_STOP];
  assign cont_req    = block_gap_control_register[BG_CONT];
  assign arm_ok      = !(transfer_mode_register_in[TM_CNT_EN] && (block_count_register == 16'd0));
  assign arm_blocks  = (transfer_mode_register_in[TM_MULTI] && transfer_mode_register_in[TM_CNT_EN])
                       ? CNT_W'(block_count_register) : CNT_W'(1);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start_q && dma_en && (block_size_register[11:0] != 12'd0)) state_next = ST_ARM;
      ST_ARM:      state_next = arm_ok ? ST_XFER : ST_IDLE;
      ST_XFER:     if (last_beat) state_next = ST_GAP_CHK;
      ST_GAP_CHK: begin
        if (rem_q <= CNT_W'(1))  state_next = ST_DONE;
        else if (stop_gap)       state_next = ST_GAP_STOP;
        else                     state_next = ST_XFER;
      end
      ST_GAP_STOP: if (cont_req && !stop_gap) state_next = ST_XFER;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    // Dropping DMA enable abandons the transfer from any active state.
    if ((state != ST_IDLE) && !dma_en) state_next = ST_IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      cmd_prev    <= 1'b0;
      start_q     <= 1'b0;
      dir_q       <= 1'b0;
      blk_start_q <= 1'b0;
      rem_q       <= '0;
    end else begin
      state       <= state_next;
      cmd_prev    <= cmd_is_data;
      start_q     <= cmd_is_data && !cmd_prev;
      blk_start_q <= (state_next == ST_XFER) && (state != ST_XFER);
      if (state == ST_ARM) dir_q <= transfer_mode_register_in[TM_DIR];
      if (state_next == ST_IDLE)  rem_q <= '0;
      else if (state == ST_ARM)   rem_q <= arm_blocks;
      else if (state == ST_GAP_CHK) rem_q <= rem_q - CNT_W'(1);
    end
  end

  adma_beat_counter #(.WORD_BYTES(WORD_BYTES)) u_beat_counter (
    .clk        (CLK),
    .rst        (RESET),
    .load       (state == ST_ARM),
    .clear      (state == ST_IDLE),
    .beat_en    ((state == ST_XFER) && beat_valid),
    .block_size (block_size_register[11:0]),
    .last_beat  (last_beat),
    .beat_cnt   (beat_cnt)
  );

  // Direction is only meaningful once ARM has latched it.
  assign direction        = dir_q && (state != ST_IDLE) && (state != ST_ARM);
  assign beat_ready       = (state == ST_XFER);
  assign blk_start        = blk_start_q;
  assign xfer_active      = (state != ST_IDLE);
  assign gap_stopped      = (state == ST_GAP_STOP);
  assign xfer_complete    = (state == ST_DONE);
  assign blocks_remaining = rem_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_adma_xfer_sched.sv
// Bench for adma_xfer_sched: table of transfer shapes, randomized transfers
// against a cycle-timeline model, and hand sequences for gap stop, abort, reset.
module tb_adma_xfer_sched;
  import adma_xfer_sched_pkg::*;

  localparam int CNT_W = 16;
  localparam int MAXC  = 400;
  localparam int NV    = 11;
  localparam int NR    = 25;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] tm, bg, bsz, bcnt, cmd;
  logic        beat_valid;
  logic        beat_ready, blk_start, xfer_active, direction, gap_stopped, xfer_complete;
  logic [CNT_W-1:0] blocks_remaining;
  xfer_state_e state_dbg;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  adma_xfer_sched #(.WORD_BYTES(4), .CNT_W(CNT_W)) dut (
    .CLK                        (CLK),
    .RESET                      (RESET),
    .transfer_mode_register_in  (tm),
    .block_gap_control_register (bg),
    .block_size_register        (bsz),
    .block_count_register       (bcnt),
    .command_register           (cmd),
    .beat_valid                 (beat_valid),
    .beat_ready                 (beat_ready),
    .blk_start                  (blk_start),
    .xfer_active                (xfer_active),
    .direction                  (direction),
    .gap_stopped                (gap_stopped),
    .xfer_complete              (xfer_complete),
    .blocks_remaining           (blocks_remaining),
    .state_dbg                  (state_dbg)
  );

  typedef struct {
    logic [15:0] size;
    logic [15:0] count;
    logic        multi;
    logic        cen;
    logic        en;
    int          exp_nblk;
    int          exp_span;
  } vec_t;

  vec_t tab[NV];

  // Timeline model storage
  bit vv[MAXC];
  bit exp_blk[MAXC], exp_cmp[MAXC], exp_act[MAXC], exp_rdy[MAXC], exp_dir[MAXC];
  int exp_rem[MAXC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_cmd();
    cmd = 16'h0080;
    tick();
    cmd = 16'h0000;
  endtask

  task automatic set_tm(input logic en, input logic cen, input logic dir, input logic multi);
    tm = '0;
    tm[TM_DMA_EN] = en;
    tm[TM_CNT_EN] = cen;
    tm[TM_DIR]    = dir;
    tm[TM_MULTI]  = multi;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nc, t_first, t_cmp, limit;
    int sz, cn, wpb, nblk, arm, s, e, cnt_b, done, nrun, c_cmd;
    bit en, cen, multi, dir;

    tab[0]  = '{16'd512,  16'd3, 1'b1, 1'b1, 1'b1, 3, 387};
    tab[1]  = '{16'd6,    16'd1, 1'b0, 1'b0, 1'b1, 1, 3};
    tab[2]  = '{16'd5,    16'd2, 1'b1, 1'b1, 1'b1, 2, 6};
    tab[3]  = '{16'd1,    16'd4, 1'b1, 1'b1, 1'b1, 4, 8};
    tab[4]  = '{16'd8,    16'd7, 1'b1, 1'b0, 1'b1, 1, 3};
    tab[5]  = '{16'd16,   16'd5, 1'b0, 1'b1, 1'b1, 1, 5};
    tab[6]  = '{16'd4095, 16'd1, 1'b0, 1'b0, 1'b1, 1, 1025};
    tab[7]  = '{16'd0,    16'd3, 1'b1, 1'b1, 1'b1, 0, 0};
    tab[8]  = '{16'd8,    16'd0, 1'b1, 1'b1, 1'b1, 0, 0};
    tab[9]  = '{16'd8,    16'd2, 1'b1, 1'b1, 1'b0, 0, 0};
    tab[10] = '{16'd13,   16'd2, 1'b1, 1'b1, 1'b1, 2, 10};

    // ---- reset state ----
    RESET = 1'b1;
    tm = '0; bg = '0; bsz = '0; bcnt = '0; cmd = '0; beat_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_active",    xfer_active,      0);
    chk("rst_ready",     beat_ready,       0);
    chk("rst_blk_start", blk_start,        0);
    chk("rst_complete",  xfer_complete,    0);
    chk("rst_gap",       gap_stopped,      0);
    chk("rst_dir",       direction,        0);
    chk("rst_remaining", blocks_remaining, 0);
    RESET = 1'b0;
    tick();

    // ---- table-driven transfer shapes, beat_valid every cycle ----
    for (int v = 0; v < NV; v++) begin
      bsz = tab[v].size;
      bcnt = tab[v].count;
      set_tm(tab[v].en, tab[v].cen, 1'b0, tab[v].multi);
      beat_valid = 1'b1;
      start_cmd();
      nb = 0; nc = 0; t_first = -1; t_cmp = -1;
      limit = (tab[v].exp_nblk > 0) ? 1300 : 20;
      for (int i = 1; i < limit; i++) begin
        if (blk_start) begin
          nb++;
          if (t_first < 0) t_first = i;
        end
        if (xfer_complete) begin
          nc++;
          t_cmp = i;
          break;
        end
        tick();
      end
      repeat (5) begin
        tick();
        if (blk_start) nb++;
        if (xfer_complete) nc++;
      end
      chk($sformatf("tab%0d_nblk", v), nb, tab[v].exp_nblk);
      chk($sformatf("tab%0d_ncomplete", v), nc, (tab[v].exp_nblk > 0) ? 1 : 0);
      chk($sformatf("tab%0d_idle_after", v), xfer_active, 0);
      if (tab[v].exp_nblk > 0) begin
        chk($sformatf("tab%0d_latency", v), t_first, 3);
        chk($sformatf("tab%0d_span", v), t_cmp - t_first, tab[v].exp_span);
      end
      beat_valid = 1'b0;
      tick();
    end

    // ---- randomized transfers against a timeline model ----
    for (int r = 0; r < NR; r++) begin
      sz    = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 64);
      cn    = $urandom_range(0, 5);
      multi = $urandom_range(0, 1);
      cen   = $urandom_range(0, 1);
      en    = ($urandom_range(0, 7) != 0);
      dir   = $urandom_range(0, 1);
      c_cmd = $urandom_range(0, 3);
      for (int k = 0; k < MAXC; k++) begin
        vv[k] = (k > 250) ? 1'b1 : ($urandom_range(0, 3) != 0);
        exp_blk[k] = 0; exp_cmp[k] = 0; exp_act[k] = 0;
        exp_rdy[k] = 0; exp_dir[k] = 0; exp_rem[k] = 0;
      end
      arm = c_cmd + 2;
      done = c_cmd + 2;
      if (en && sz != 0) begin
        exp_act[arm] = 1;
        if (!(cen && cn == 0)) begin
          nblk = (multi && cen) ? cn : 1;
          wpb = (sz + 3) / 4;
          s = arm + 1;
          e = s;
          for (int b = 0; b < nblk; b++) begin
            exp_blk[s] = 1;
            cnt_b = 0;
            e = s;
            while (1) begin
              exp_rdy[e] = 1;
              if (vv[e]) begin
                cnt_b++;
                if (cnt_b == wpb) break;
              end
              e++;
            end
            for (int t = s; t <= e + 1; t++) exp_rem[t] = nblk - b;
            s = e + 2;
          end
          done = e + 2;
          exp_cmp[done] = 1;
          for (int t = arm; t <= done; t++) exp_act[t] = 1;
          for (int t = arm + 1; t <= done; t++) exp_dir[t] = dir;
        end
      end
      nrun = done + 3;
      for (int c = 0; c < nrun; c++) begin
        cmd = (c == c_cmd) ? 16'h0080 : 16'h0000;
        beat_valid = vv[c];
        bg = '0;
        bg[BG_CONT] = $urandom_range(0, 1);
        if (c <= c_cmd + 2) begin
          set_tm(en, cen, dir, multi);
          bsz = 16'(sz);
          bcnt = 16'(cn);
        end else begin
          tm = 16'($urandom);
          tm[TM_DMA_EN] = en;
          bsz = 16'($urandom);
          bcnt = 16'($urandom);
        end
        @(negedge CLK);
        chk($sformatf("rnd%0d_c%0d_blk_start", r, c), blk_start, exp_blk[c]);
        chk($sformatf("rnd%0d_c%0d_complete", r, c), xfer_complete, exp_cmp[c]);
        chk($sformatf("rnd%0d_c%0d_active", r, c), xfer_active, exp_act[c]);
        chk($sformatf("rnd%0d_c%0d_ready", r, c), beat_ready, exp_rdy[c]);
        chk($sformatf("rnd%0d_c%0d_remaining", r, c), blocks_remaining, 32'(exp_rem[c]));
        chk($sformatf("rnd%0d_c%0d_direction", r, c), direction, exp_dir[c]);
        chk($sformatf("rnd%0d_c%0d_gap", r, c), gap_stopped, 0);
        @(posedge CLK);
        #1;
      end
    end
    cmd = '0; bg = '0; beat_valid = 1'b0;
    tick();

    // ---- command held high for 50 cycles: one transfer only ----
    set_tm(1'b1, 1'b0, 1'b0, 1'b0);
    bsz = 16'd4; bcnt = 16'd0; beat_valid = 1'b1;
    cmd = 16'h0080;
    nb = 0; nc = 0;
    repeat (50) begin
      tick();
      if (blk_start) nb++;
      if (xfer_complete) nc++;
    end
    cmd = 16'h0000;
    repeat (5) begin
      tick();
      if (blk_start) nb++;
      if (xfer_complete) nc++;
    end
    chk("hold_nblk", nb, 1);
    chk("hold_ncomplete", nc, 1);

    // ---- stop at block gap during block 2, then continue ----
    set_tm(1'b1, 1'b1, 1'b0, 1'b1);
    bsz = 16'd8; bcnt = 16'd4; bg = '0; beat_valid = 1'b1;
    start_cmd();
    nb = 0; nc = 0;
    for (int i = 0; i < 100 && nb < 2; i++) begin
      tick();
      if (blk_start) nb++;
    end
    chk("stop_reach_blk2", nb, 2);
    bg[BG_STOP] = 1'b1;
    for (int i = 0; i < 20 && !gap_stopped; i++) begin
      tick();
      if (blk_start) nb++;
      if (xfer_complete) nc++;
    end
    chk("stop_gap_stopped", gap_stopped, 1);
    chk("stop_ready_low", beat_ready, 0);
    chk("stop_remaining", blocks_remaining, 2);
    chk("stop_nblk_held", nb, 2);
    repeat (5) tick();
    chk("stop_still_held", gap_stopped, 1);
    bg = 16'h0003;
    repeat (3) tick();
    chk("stop_cont_ignored", gap_stopped, 1);
    bg = 16'h0002;
    tick();
    if (blk_start) nb++;
    bg = '0;
    for (int i = 0; i < 100 && nc == 0; i++) begin
      tick();
      if (blk_start) nb++;
      if (xfer_complete) nc++;
    end
    chk("stop_total_nblk", nb, 4);
    chk("stop_ncomplete", nc, 1);
    tick();
    tick();
    chk("stop_idle_after", xfer_active, 0);

    // ---- DMA enable dropped mid-block 2 ----
    set_tm(1'b1, 1'b1, 1'b0, 1'b1);
    bsz = 16'd8; bcnt = 16'd4; beat_valid = 1'b1;
    start_cmd();
    nb = 0; nc = 0;
    for (int i = 0; i < 100 && nb < 2; i++) begin
      tick();
      if (blk_start) nb++;
    end
    chk("abort_reach_blk2", nb, 2);
    tm[TM_DMA_EN] = 1'b0;
    tick();
    chk("abort_active", xfer_active, 0);
    chk("abort_ready", beat_ready, 0);
    repeat (10) begin
      if (xfer_complete) nc++;
      tick();
    end
    chk("abort_no_complete", nc, 0);

    // ---- asynchronous reset mid-block ----
    set_tm(1'b1, 1'b0, 1'b1, 1'b0);
    bsz = 16'd64; bcnt = 16'd1; beat_valid = 1'b1;
    start_cmd();
    nb = 0;
    for (int i = 0; i < 20 && nb < 1; i++) begin
      tick();
      if (blk_start) nb++;
    end
    repeat (3) tick();
    chk("rstmid_dir_before", direction, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("rstmid_active", xfer_active, 0);
    chk("rstmid_ready", beat_ready, 0);
    chk("rstmid_dir", direction, 0);
    chk("rstmid_remaining", blocks_remaining, 0);
    @(posedge CLK);
    #3;
    RESET = 1'b0;
    nb = 0;
    repeat (10) begin
      tick();
      if (blk_start) nb++;
    end
    chk("rstmid_no_restart", nb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
